// File: rtl/store_wb_buffer.sv
// store_wb_buffer
//   Post-retirement store write buffer. Retired stores (up to WAYS per cycle)
//   are compacted into a circular FIFO, drained one at a time to the data
//   cache over a valid/ready request, and forwarded byte-wise to two load
//   ports (youngest buffered store wins per byte).
//
//   Optional feature macro: STORE_WB_MERGE_EN
//     When defined, an incoming store whose address equals the youngest valid
//     entry merges into it (bytes OR'd / overwritten) instead of allocating.
//     The head entry is never a merge target while it is being requested.
//
// Ports
//   clock, reset            clock, asynchronous active-high reset
//   in_valid/addr/data/usebytes  retiring stores per way (way 0 oldest)
//   in_stall                fewer than WAYS free entries
//   dc_req_valid/addr/data/usebytes, dc_req_ready  cache write request
//   ld_addr, ld_fwd_data, ld_fwd_usebytes          two forwarding ports
//   empty, count            occupancy
module store_wb_buffer #(
    parameter int WAYS       = 2,
    parameter int DEPTH      = 8,
    parameter int DEPTH_BITS = $clog2(DEPTH)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [WAYS-1:0]            in_valid,
    input  logic [WAYS-1:0][31:0]      in_addr,
    input  logic [WAYS-1:0][31:0]      in_data,
    input  logic [WAYS-1:0][3:0]       in_usebytes,
    output logic                       in_stall,
    output logic                       dc_req_valid,
    output logic [31:0]                dc_req_addr,
    output logic [31:0]                dc_req_data,
    output logic [3:0]                 dc_req_usebytes,
    input  logic                       dc_req_ready,
    input  logic [1:0][31:0]           ld_addr,
    output logic [1:0][31:0]           ld_fwd_data,
    output logic [1:0][3:0]            ld_fwd_usebytes,
    output logic                       empty,
    output logic [DEPTH_BITS:0]        count
);

    typedef enum logic {IDLE, REQ} state_t;

    localparam logic [DEPTH_BITS:0] STALL_TH = (DEPTH_BITS+1)'(DEPTH - WAYS);

    state_t                     state, state_next;
    logic [DEPTH_BITS-1:0]      head, tail, head_next, tail_next;
    logic [DEPTH_BITS:0]        count_next;
    logic [DEPTH-1:0]           ent_valid, ent_valid_next;
    logic [DEPTH-1:0][31:0]     ent_addr, ent_addr_next;
    logic [DEPTH-1:0][31:0]     ent_data, ent_data_next;
    logic [DEPTH-1:0][3:0]      ent_use, ent_use_next;
    logic                       deq;

`ifdef STORE_WB_MERGE_EN
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_d,
                                                input logic [31:0] new_d,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_d;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_d[8*b +: 8];
        end
        return res;
    endfunction
`endif

    assign dc_req_valid    = (state == REQ);
    assign dc_req_addr     = dc_req_valid ? ent_addr[head] : '0;
    assign dc_req_data     = dc_req_valid ? ent_data[head] : '0;
    assign dc_req_usebytes = dc_req_valid ? ent_use[head]  : '0;
    assign deq             = dc_req_valid & dc_req_ready;
    assign in_stall        = (count > STALL_TH);
    assign empty           = (count == '0);

    // Next-state: dequeue at head, then compact valid ways from tail upward.
    always_comb begin
        logic [DEPTH_BITS-1:0] wr_ptr;
        logic [DEPTH_BITS:0]   enq;
        logic                  merge;
`ifdef STORE_WB_MERGE_EN
        logic [DEPTH_BITS-1:0] y_idx;
        logic                  y_ok;
`endif
        ent_valid_next = ent_valid;
        ent_addr_next  = ent_addr;
        ent_data_next  = ent_data;
        ent_use_next   = ent_use;
        wr_ptr         = tail;
        enq            = '0;
        merge          = 1'b0;
`ifdef STORE_WB_MERGE_EN
        // Youngest existing entry is a merge target unless it is the head
        // currently presented to the cache.
        y_idx = tail - 1'b1;
        y_ok  = ent_valid[y_idx] && !((state == REQ) && (y_idx == head));
`endif
        if (deq) begin
            ent_valid_next[head] = 1'b0;
            ent_addr_next[head]  = '0;
            ent_data_next[head]  = '0;
            ent_use_next[head]   = '0;
        end
        for (int w = 0; w < WAYS; w++) begin
            merge = 1'b0;
            if (in_valid[w]) begin
`ifdef STORE_WB_MERGE_EN
                merge = y_ok && (ent_addr_next[y_idx] == in_addr[w]);
                if (merge) begin
                    ent_data_next[y_idx] = merge_bytes(ent_data_next[y_idx], in_data[w], in_usebytes[w]);
                    ent_use_next[y_idx]  = ent_use_next[y_idx] | in_usebytes[w];
                end
`endif
                if (!merge) begin
                    ent_valid_next[wr_ptr] = 1'b1;
                    ent_addr_next[wr_ptr]  = in_addr[w];
                    ent_data_next[wr_ptr]  = in_data[w];
                    ent_use_next[wr_ptr]   = in_usebytes[w];
`ifdef STORE_WB_MERGE_EN
                    // A later way may merge into this same-cycle allocation.
                    y_idx = wr_ptr;
                    y_ok  = 1'b1;
`endif
                    wr_ptr = wr_ptr + 1'b1;
                    enq    = enq + 1'b1;
                end
            end
        end
        tail_next  = wr_ptr;
        head_next  = deq ? head + 1'b1 : head;
        count_next = count + enq - {{DEPTH_BITS{1'b0}}, deq};
    end

    // Drain FSM: looking at count_next lets a store written into an empty
    // buffer be requested on the very next cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (count_next != '0) state_next = REQ;
            REQ:     if (count_next == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
            ent_addr  <= '0;
            ent_data  <= '0;
            ent_use   <= '0;
        end else begin
            state     <= state_next;
            head      <= head_next;
            tail      <= tail_next;
            count     <= count_next;
            ent_valid <= ent_valid_next;
            ent_addr  <= ent_addr_next;
            ent_data  <= ent_data_next;
            ent_use   <= ent_use_next;
        end
    end

    // Forwarding: walk entries oldest-first from head so younger stores
    // overwrite older ones byte by byte, independent of physical index.
    always_comb begin
        logic [DEPTH_BITS-1:0] idx;
        ld_fwd_data     = '0;
        ld_fwd_usebytes = '0;
        idx             = '0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                idx = head + DEPTH_BITS'(i);
                if (ent_valid[idx] && (ent_addr[idx] == ld_addr[p])) begin
                    for (int b = 0; b < 4; b++) begin
                        if (ent_use[idx][b]) begin
                            ld_fwd_data[p][8*b +: 8] = ent_data[idx][8*b +: 8];
                            ld_fwd_usebytes[p][b]    = 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_store_wb_buffer.sv
// Testbench for store_wb_buffer: randomized and directed stores checked by a
// scoreboard; the reference model is a queue of buffered stores in age order.
module tb_store_wb_buffer;
    localparam int WAYS  = 2;
    localparam int DEPTH = 8;
    localparam int DB    = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } st_t;

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    logic [WAYS-1:0]       in_valid = '0;
    logic [WAYS-1:0][31:0] in_addr = '0;
    logic [WAYS-1:0][31:0] in_data = '0;
    logic [WAYS-1:0][3:0]  in_usebytes = '0;
    logic                  in_stall;
    logic                  dc_req_valid;
    logic [31:0]           dc_req_addr;
    logic [31:0]           dc_req_data;
    logic [3:0]            dc_req_usebytes;
    logic                  dc_req_ready = 1'b0;
    logic [1:0][31:0]      ld_addr = '0;
    logic [1:0][31:0]      ld_fwd_data;
    logic [1:0][3:0]       ld_fwd_usebytes;
    logic                  empty;
    logic [DB:0]           count;

    store_wb_buffer #(.WAYS(WAYS), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data), .in_usebytes(in_usebytes),
        .in_stall(in_stall),
        .dc_req_valid(dc_req_valid), .dc_req_addr(dc_req_addr), .dc_req_data(dc_req_data),
        .dc_req_usebytes(dc_req_usebytes), .dc_req_ready(dc_req_ready),
        .ld_addr(ld_addr), .ld_fwd_data(ld_fwd_data), .ld_fwd_usebytes(ld_fwd_usebytes),
        .empty(empty), .count(count)
    );

    always #5 clock = ~clock;

    st_t buf_q[$];    // model contents, oldest first; front is the expected cache write
    st_t issue_q[$];  // stores driven this cycle, not yet committed to the model
    int  compared = 0;
    int  mismatched = 0;
    bit  mon_en = 1'b0;

    function automatic st_t mk(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        st_t s;
        s.addr = a; s.data = d; s.be = b;
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_fwd(input logic [31:0] a, output logic [31:0] d, output logic [3:0] u);
        d = '0;
        u = '0;
        foreach (buf_q[i]) begin
            if (buf_q[i].addr == a) begin
                for (int b = 0; b < 4; b++) begin
                    if (buf_q[i].be[b]) begin
                        d[8*b +: 8] = buf_q[i].data[8*b +: 8];
                        u[b] = 1'b1;
                    end
                end
            end
        end
    endfunction

    task automatic monitor_step();
        int          n;
        logic [31:0] fd;
        logic [3:0]  fu;
        st_t         s;
        bit          merge_ok;
        n = buf_q.size();
        check("count", 32'(count), n);
        check("empty", 32'(empty), 32'(n == 0));
        check("in_stall", 32'(in_stall), 32'((DEPTH - n) < WAYS));
        check("req_valid", 32'(dc_req_valid), 32'(n > 0));
        if (n > 0) begin
            check("req_addr", dc_req_addr, buf_q[0].addr);
            check("req_data", dc_req_data, buf_q[0].data);
            check("req_be", 32'(dc_req_usebytes), 32'(buf_q[0].be));
        end
        for (int p = 0; p < 2; p++) begin
            model_fwd(ld_addr[p], fd, fu);
            check($sformatf("fwd_data%0d", p), ld_fwd_data[p], fd);
            check($sformatf("fwd_be%0d", p), 32'(ld_fwd_usebytes[p]), 32'(fu));
        end
        check("valid_while_stalled", 32'(|in_valid & in_stall), 32'd0);
        if (dc_req_valid && dc_req_ready && n > 0) void'(buf_q.pop_front());
        // The youngest existing entry can absorb a store only if it is not the head.
        merge_ok = (n >= 2);
        while (issue_q.size() > 0) begin
            s = issue_q.pop_front();
`ifdef STORE_WB_MERGE_EN
            if (merge_ok && buf_q.size() > 0 && buf_q[buf_q.size()-1].addr == s.addr) begin
                st_t y;
                int  k;
                k = buf_q.size() - 1;
                y = buf_q[k];
                for (int b = 0; b < 4; b++)
                    if (s.be[b]) y.data[8*b +: 8] = s.data[8*b +: 8];
                y.be = y.be | s.be;
                buf_q[k] = y;
            end else begin
                buf_q.push_back(s);
                merge_ok = 1'b1;
            end
`else
            buf_q.push_back(s);
            merge_ok = 1'b1;
`endif
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (mon_en) monitor_step();
        end
    end

    // One cycle of stimulus, applied just after the rising edge.
    task automatic drive(input logic [WAYS-1:0] v, input st_t s0, input st_t s1, input logic rdy,
                         input logic [31:0] la0, input logic [31:0] la1);
        @(posedge clock);
        #1;
        if (in_stall) v = '0;
        in_valid       = v;
        in_addr[0]     = s0.addr; in_data[0] = s0.data; in_usebytes[0] = s0.be;
        in_addr[1]     = s1.addr; in_data[1] = s1.data; in_usebytes[1] = s1.be;
        dc_req_ready   = rdy;
        ld_addr[0]     = la0;
        ld_addr[1]     = la1;
        if (v[0]) issue_q.push_back(s0);
        if (v[1]) issue_q.push_back(s1);
    endtask

    task automatic idle(input logic rdy, input logic [31:0] la0, input logic [31:0] la1);
        drive('0, '0, '0, rdy, la0, la1);
    endtask

    task automatic drain();
        int budget;
        budget = 200;
        idle(1'b1, 32'h0, 32'h0);
        while (!empty && budget > 0) begin
            idle(1'b1, 32'h0, 32'h0);
            budget--;
        end
        check("drain_empty", 32'(empty), 32'd1);
    endtask

    initial begin
        logic [WAYS-1:0] v;
        st_t a, b;

        // Reset state
        #2 reset = 1'b1;
        #2;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_stall", 32'(in_stall), 32'd0);
        check("rst_req_valid", 32'(dc_req_valid), 32'd0);
        check("rst_req_addr", dc_req_addr, 32'd0);
        check("rst_req_data", dc_req_data, 32'd0);
        check("rst_req_be", 32'(dc_req_usebytes), 32'd0);
        check("rst_fwd_be", 32'(ld_fwd_usebytes), 32'd0);
        check("rst_fwd_data0", ld_fwd_data[0], 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        mon_en = 1'b1;

        // Single store, next-cycle request, empty two cycles after enqueue
        drive(2'b01, mk(32'h100, 32'hAABBCCDD, 4'hF), '0, 1'b1, 32'h100, 32'h0);
        idle(1'b1, 32'h100, 32'h0);
        check("t1_req_valid", 32'(dc_req_valid), 32'd1);
        check("t1_req_addr", dc_req_addr, 32'h100);
        check("t1_req_data", dc_req_data, 32'hAABBCCDD);
        check("t1_req_be", 32'(dc_req_usebytes), 32'hF);
        idle(1'b1, 32'h100, 32'h0);
        check("t1_empty", 32'(empty), 32'd1);

        // Three stores held by ready=0 for five cycles, then drain in order
        drive(2'b11, mk(32'h10, 32'h01010101, 4'hF), mk(32'h14, 32'h02020202, 4'h3), 1'b0, 32'h10, 32'h14);
        drive(2'b01, mk(32'h18, 32'h03030303, 4'hC), '0, 1'b0, 32'h18, 32'h10);
        repeat (5) idle(1'b0, 32'h14, 32'h18);
        drain();

        // Fill to DEPTH-1 with ready low, then release one entry
        for (int i = 0; i < 3; i++)
            drive(2'b11, mk(32'h400 + 32'(8*i), 32'(i), 4'hF), mk(32'h404 + 32'(8*i), 32'(i+16), 4'h1),
                  1'b0, 32'h400, 32'h404);
        drive(2'b01, mk(32'h430, 32'hCAFEF00D, 4'hF), '0, 1'b0, 32'h430, 32'h400);
        idle(1'b0, 32'h430, 32'h400);
        check("fill_stall", 32'(in_stall), 32'd1);
        idle(1'b1, 32'h430, 32'h400);
        idle(1'b0, 32'h430, 32'h400);
        check("fill_unstall", 32'(in_stall), 32'd0);
        drain();

        // Youngest-wins byte forwarding
        drive(2'b01, mk(32'h200, 32'h11223344, 4'hF), '0, 1'b0, 32'h200, 32'h204);
        drive(2'b01, mk(32'h200, 32'h0000EE00, 4'b0010), '0, 1'b0, 32'h200, 32'h204);
        idle(1'b0, 32'h200, 32'h204);
        check("fwd_AB_data", ld_fwd_data[0], 32'h1122EE44);
        check("fwd_AB_be", 32'(ld_fwd_usebytes[0]), 32'hF);
        check("fwd_miss_be", 32'(ld_fwd_usebytes[1]), 32'h0);
        drain();

`ifdef STORE_WB_MERGE_EN
        // Two same-cycle stores to one word merge into a single entry
        drive(2'b11, mk(32'h300, 32'h000000AA, 4'b0001), mk(32'h300, 32'h00BB0000, 4'b0100),
              1'b0, 32'h300, 32'h0);
        idle(1'b0, 32'h300, 32'h0);
        check("merge_count", 32'(count), 32'd1);
        check("merge_req_be", 32'(dc_req_usebytes), 32'b0101);
        check("merge_req_data", dc_req_data, 32'h00BB00AA);
        drain();
`endif

        // Random traffic across several pointer wraps
        for (int c = 0; c < 120; c++) begin
            v = WAYS'($urandom_range(0, 3));
            a = mk(32'h200 + 32'(4 * $urandom_range(0, 3)), $urandom, 4'($urandom_range(1, 15)));
            b = mk(32'h200 + 32'(4 * $urandom_range(0, 3)), $urandom, 4'($urandom_range(1, 15)));
            drive(v, a, b, 1'($urandom_range(0, 2) != 0),
                  32'h200 + 32'(4 * $urandom_range(0, 3)), 32'h200 + 32'(4 * $urandom_range(0, 3)));
        end
        drain();

        // Asynchronous reset while a request is pending
        drive(2'b11, mk(32'h500, 32'h55555555, 4'hF), mk(32'h504, 32'h66666666, 4'hF), 1'b0, 32'h500, 32'h504);
        idle(1'b0, 32'h500, 32'h504);
        @(posedge clock);
        #1;
        mon_en = 1'b0;
        in_valid = '0;
        #2 reset = 1'b1;
        #1;
        check("arst_req_valid", 32'(dc_req_valid), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_empty", 32'(empty), 32'd1);
        check("arst_fwd_be", 32'(ld_fwd_usebytes), 32'd0);
        buf_q.delete();
        issue_q.delete();
        @(posedge clock);
        #1 reset = 1'b0;
        mon_en = 1'b1;
        drive(2'b10, '0, mk(32'h600, 32'h12345678, 4'h6), 1'b1, 32'h600, 32'h0);
        drain();

        @(negedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/store_wb_buffer.md
Name: store_wb_buffer

Overview:
- Post-retirement store write buffer, directly downstream of the store queue.
- Accepts up to WAYS retired stores per cycle from the store queue's retire/write-back outputs and holds them in a circular FIFO.
- Drains them one at a time to the data cache through a valid/ready request handshake.
- Provides byte-granular forwarding of buffered stores to loads, so retired-but-unwritten data stays visible.

Parameters:
- WAYS, 2, retire width (stores accepted per cycle).
- DEPTH, 8, buffer entries; power of two, at least WAYS.
- DEPTH_BITS, $clog2(DEPTH), index width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  WAYS  retiring store present per way; lower way is older.
- in_addr  in  WAYS x 32  word-aligned store address.
- in_data  in  WAYS x 32  store data, bytes positioned in word.
- in_usebytes  in  WAYS x 4  byte enables.
- in_stall  out  1  asserted when fewer than WAYS free entries.
- dc_req_valid  out  1  write request to data cache.
- dc_req_addr  out  32  head entry address.
- dc_req_data  out  32  head entry data.
- dc_req_usebytes  out  4  head entry byte enables.
- dc_req_ready  in  1  cache accepts the request this cycle.
- ld_addr  in  2 x 32  load lookup addresses (two load ports).
- ld_fwd_data  out  2 x 32  forwarded bytes; zero where not forwarded.
- ld_fwd_usebytes  out  2 x 4  bytes supplied by the buffer.
- empty  out  1  no entries held (used for fence/halt drain).
- count  out  DEPTH_BITS+1  occupied entries.

Behaviour:
- State: head and tail pointers (DEPTH_BITS each, wrap modulo DEPTH), count (DEPTH_BITS+1), and a per-entry record {valid, addr, data, usebytes}.
- Reset (asynchronous): head=tail=count=0, all entries cleared. Outputs at reset: in_stall=0, dc_req_valid=0, dc_req_* = 0, ld_fwd_* = 0, empty=1, count=0.
- Enqueue: set ways of in_valid are compacted in way order and written at tail, tail+1, … The new tail and count are visible the next cycle.
- Upstream contract: in_valid must not be set while in_stall=1. Violation is undefined; the bench asserts it never happens.
- in_stall = (DEPTH - count) < WAYS; purely combinational from registered count.
- Drain FSM has two states:
  - IDLE: dc_req_valid=0; move to REQ when count>0.
  - REQ: dc_req_valid=1 with the head entry's fields.
- Handshake: on dc_req_valid & dc_req_ready, the head is cleared and head advances by 1 at the clock edge. Stay in REQ if count after update >0, else go to IDLE.
- While waiting for ready, dc_req_* must be held stable; they come from the registered head entry only.
- Request latency: a store enqueued into an empty buffer at cycle N drives dc_req_valid at cycle N+1.
- Simultaneous enqueue and dequeue in one cycle: count_next = count + enq - deq. Full-to-not-full and empty-to-not-empty transitions are both legal in the same cycle.
- Forwarding (combinational), for each load port p:
  - Scan valid entries from oldest to youngest; a younger entry overrides older ones per byte.
  - An entry matches when its addr equals ld_addr[p] (full 32-bit compare).
  - For each matching byte b with usebytes[b]=1: ld_fwd_data[p] byte b = entry data byte b, and ld_fwd_usebytes[p][b]=1.
  - Same-cycle incoming stores are not forwarded; the store queue covers them.
  - The head entry in REQ remains forwardable until the handshake completes.
- Wrap-around: pointer arithmetic is modulo DEPTH. Youngest-wins ordering follows logical age from head, not physical index.
- Reset mid-request: buffer contents are discarded and dc_req_valid drops immediately (asynchronous).

Optional Feature:
- Macro: STORE_WB_MERGE_EN.
- Defined: an incoming store whose addr matches the youngest valid entry (tail-1) is merged into that entry instead of allocating a new one.
  - Merge: new usebytes OR'd in; new bytes overwrite.
  - Merging is not allowed into the head while it is in REQ.
  - Way 1 may merge into way 0's same-cycle allocation.
  - Merged stores do not advance tail or count.
- Undefined: every valid way allocates a new entry.

Test Plan:
- Reset then one store (addr 0x100, data 0xAABBCCDD, usebytes 4'hF), dc_req_ready=1 -> dc_req_valid at cycle+1 with those fields; empty=1 two cycles after enqueue.
- dc_req_ready held 0 for 5 cycles with 3 stores queued -> dc_req_* stable all 5 cycles; the three stores issue in order once ready=1; count steps 3,2,1,0.
- Fill to DEPTH-1 with ready=0 -> in_stall=1 (free=1 < WAYS=2); one accepted request -> in_stall=0 next cycle.
- Entry A (0x200, 0x11223344, 4'hF) then B (0x200, 0x0000EE00, 4'b0010), ld_addr[0]=0x200 -> ld_fwd_data=0x1122EE44, ld_fwd_usebytes=4'hF; ld_addr[1]=0x204 -> usebytes 0.
- Run 3×DEPTH stores with random ready stalls across pointer wrap -> cache sees every store exactly once, in program order; youngest-wins forwarding stays correct across the wrap.
- With STORE_WB_MERGE_EN: two ways same cycle to 0x300, usebytes 4'b0001 and 4'b0100 -> count increments by 1; the single request carries usebytes 4'b0101.
